// File: rtl/axil_timer.sv
// AXI4-Lite memory-mapped timer: 64-bit mtime with prescaler, 64-bit compare and a level interrupt.
// Register reads are single-cycle; reading MTIME_LO snapshots the upper half so MTIME_HI pairs with it.
module axil_timer #(
  parameter int PRESC_W      = 16,
  parameter bit RESET_ENABLE = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        timer_irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [9:0] ADDR_MTIME_LO = 10'd0;
  localparam logic [9:0] ADDR_MTIME_HI = 10'd1;
  localparam logic [9:0] ADDR_CMP_LO   = 10'd2;
  localparam logic [9:0] ADDR_CMP_HI   = 10'd3;
  localparam logic [9:0] ADDR_CTRL     = 10'd4;
  localparam logic [9:0] ADDR_PRESCALE = 10'd5;

  logic               awready_q, awready_d, wready_q, wready_d;
  logic               aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [9:0]         aw_addr_q, aw_addr_d;
  logic [31:0]        w_data_q, w_data_d;
  logic [3:0]         w_strb_q, w_strb_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [63:0]        mtime_q, mtime_d, cmp_q, cmp_d;
  logic               enable_q, enable_d, irq_en_q, irq_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
  logic [31:0]        hi_shadow_q, hi_shadow_d;
  logic               irq_q, irq_d;

  logic        aw_hs, w_hs, ar_hs, commit, wr_hit, wr_en;
  logic [9:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, wmask, presc_ext;
  logic [3:0]  wr_strb;
  logic        unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:12], s_axi_awaddr[1:0],
                       s_axi_araddr[31:12], s_axi_araddr[1:0]};

  assign aw_hs   = s_axi_awvalid && awready_q;
  assign w_hs    = s_axi_wvalid && wready_q;
  assign ar_hs   = s_axi_arvalid && arready_q;
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr[11:2];
  assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;
  assign rd_addr = s_axi_araddr[11:2];
  // The write commits in the cycle both halves are available, held or arriving now.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_hit  = (wr_addr <= ADDR_PRESCALE);
  assign wr_en   = commit && wr_hit && (wr_strb != 4'd0);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end
  endgenerate

  always_comb begin
    presc_ext = '0;
    presc_ext[PRESC_W-1:0] = presc_q;
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    aw_held_d = aw_held_q || aw_hs;
    w_held_d  = w_held_q || w_hs;
    aw_addr_d = aw_hs ? s_axi_awaddr[11:2] : aw_addr_q;
    w_data_d  = w_hs ? s_axi_wdata : w_data_q;
    w_strb_d  = w_hs ? s_axi_wstrb : w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  always_comb begin
    mtime_d     = mtime_q;
    presc_cnt_d = presc_cnt_q;
    cmp_d       = cmp_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    presc_d     = presc_q;
    if (enable_q) begin
      if (presc_cnt_q == presc_q) begin
        presc_cnt_d = '0;
        mtime_d     = mtime_q + 64'd1;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end
    // A software write wins over the tick of the same cycle.
    if (wr_en) begin
      case (wr_addr)
        ADDR_MTIME_LO: begin
          mtime_d     = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wmask)};
          presc_cnt_d = '0;
        end
        ADDR_MTIME_HI: begin
          mtime_d     = {merge(mtime_q[63:32], wr_data, wmask), mtime_q[31:0]};
          presc_cnt_d = '0;
        end
        ADDR_CMP_LO: cmp_d = {cmp_q[63:32], merge(cmp_q[31:0], wr_data, wmask)};
        ADDR_CMP_HI: cmp_d = {merge(cmp_q[63:32], wr_data, wmask), cmp_q[31:0]};
        ADDR_CTRL: begin
          enable_d = wr_strb[0] ? wr_data[0] : enable_q;
          irq_en_d = wr_strb[0] ? wr_data[1] : irq_en_q;
        end
        ADDR_PRESCALE: begin
          for (int i = 0; i < PRESC_W; i++) begin
            presc_d[i] = wr_strb[i/8] ? wr_data[i] : presc_q[i];
          end
          presc_cnt_d = '0;
        end
        default: ;
      endcase
    end
    irq_d = irq_en_q && (mtime_q >= cmp_q);
  end

  always_comb begin
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    hi_shadow_d = hi_shadow_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (rd_addr)
        ADDR_MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        ADDR_MTIME_HI: rdata_d = hi_shadow_q;
        ADDR_CMP_LO:   rdata_d = cmp_q[31:0];
        ADDR_CMP_HI:   rdata_d = cmp_q[63:32];
        ADDR_CTRL:     rdata_d = {30'd0, irq_en_q, enable_q};
        ADDR_PRESCALE: rdata_d = presc_ext;
        default: begin
          rdata_d = 32'd0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      mtime_q     <= '0;
      cmp_q       <= '1;
      enable_q    <= RESET_ENABLE;
      irq_en_q    <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      hi_shadow_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      aw_addr_q   <= aw_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      hi_shadow_q <= hi_shadow_d;
      irq_q       <= irq_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign timer_irq     = irq_q;

endmodule

// File: tb/tb_axil_timer.sv
// Directed bench for axil_timer: register access, prescaled counting, wrap, irq, stalls, errors, reset.
module tb_axil_timer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, timer_irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_chk = 0, n_pass = 0, bcount = 0;

  always #5 aclk = ~aclk;

  axil_timer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(1'b0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(1'b0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .timer_irq(timer_irq)
  );

  always @(posedge aclk) if (bvalid && bready) bcount <= bcount + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n = 0;
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(negedge aclk); n++;
      if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
      if (w_now)  begin w_done = 1;  wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    check("wr_bvalid", bvalid, 1'b1);
    resp = bresp;
    bready = 1'b1; @(negedge aclk); bready = 1'b0;
    $display("WR addr=0x%03h data=0x%08h strb=%b resp=%0d", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    check("rd_arready", arready, 1'b1);
    araddr = addr; arvalid = 1'b1;
    @(negedge aclk); arvalid = 1'b0;
    check("rd_latency", rvalid, 1'b1);
    data = rdata; resp = rresp;
    rready = 1'b1; @(negedge aclk); rready = 1'b0;
    $display("RD addr=0x%03h data=0x%08h resp=%0d", addr, data, resp);
  endtask

  initial begin
    logic [31:0] d, d0;
    logic [1:0]  r;
    int n, b0, ones;

    // 1. reset state and basic reads
    repeat (3) @(negedge aclk);
    check("rst_outputs", {awready, wready, bvalid, arready, rvalid, timer_irq, bresp, rresp}, '0);
    check("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    axi_read(32'h000, d, r); check("rst_mtime_lo", {r, d}, {2'b00, 32'h0});
    axi_read(32'h008, d, r); check("rst_cmp_lo", {r, d}, {2'b00, 32'hFFFF_FFFF});
    axi_read(32'h010, d, r); check("rst_ctrl", {r, d}, {2'b00, 32'h0});

    // 2. W two cycles ahead of AW, then prescaled counting
    b0 = bcount;
    wdata = 32'd3; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk); wvalid = 1'b0;
    check("w_held_wready", wready, 1'b0);
    repeat (2) @(negedge aclk);
    check("no_early_b", bvalid, 1'b0);
    awaddr = 32'h014; awvalid = 1'b1;
    @(negedge aclk); awvalid = 1'b0;
    check("split_bvalid", {bvalid, bresp, awready}, {1'b1, 2'b00, 1'b0});
    bready = 1'b1; @(negedge aclk); bready = 1'b0;
    check("split_one_b", bcount - b0, 1);
    axi_read(32'h014, d, r); check("presc_rb", d, 32'd3);
    axi_write(32'h010, 32'd1, 4'hF, r);
    axi_read(32'h000, d0, r);
    repeat (38) @(negedge aclk);
    axi_read(32'h000, d, r);
    check("presc4_rate", d - d0, 32'd10);
    axi_write(32'h010, 32'd0, 4'hF, r);

    // 3. wrap from all-ones
    axi_write(32'h000, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(32'h004, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(32'h014, 32'd0, 4'hF, r);
    axi_read(32'h000, d, r); check("max_lo", d, 32'hFFFF_FFFF);
    axi_read(32'h004, d, r); check("max_hi", d, 32'hFFFF_FFFF);
    axi_write(32'h010, 32'd1, 4'hF, r);
    axi_read(32'h000, d, r); check("wrap_lo", d, 32'd0);
    axi_read(32'h004, d, r); check("wrap_hi_shadow", d, 32'd0);

    // 4. compare interrupt
    axi_write(32'h010, 32'd0, 4'hF, r);
    axi_write(32'h000, 32'd0, 4'hF, r);
    axi_write(32'h004, 32'd0, 4'hF, r);
    axi_write(32'h008, 32'h20, 4'hF, r);
    axi_write(32'h00C, 32'd0, 4'hF, r);
    check("irq_low_before", timer_irq, 1'b0);
    axi_write(32'h010, 32'd3, 4'hF, r);
    n = 0;
    while (!timer_irq && n < 100) begin @(negedge aclk); n++; end
    check("irq_rise_cycles", n, 32);
    axi_write(32'h008, 32'h100, 4'hF, r);
    check("irq_drop", timer_irq, 1'b0);
    axi_write(32'h010, 32'd0, 4'hF, r);

    // 5. B and R back-pressure
    awaddr = 32'h040; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk); awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("b_stall", {bvalid, bresp, awready, wready}, {1'b1, 2'b10, 2'b00});
      @(negedge aclk);
    end
    bready = 1'b1; @(negedge aclk); bready = 1'b0;
    check("b_release", {bvalid, awready, wready}, 3'b011);
    araddr = 32'h008; arvalid = 1'b1;
    @(negedge aclk); arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("r_stall", {rvalid, rresp, arready, rdata}, {1'b1, 2'b00, 1'b0, 32'h100});
      @(negedge aclk);
    end
    rready = 1'b1; @(negedge aclk); rready = 1'b0;
    check("r_release", {rvalid, arready}, 2'b01);

    // 6. errors, strobes, reserved bits, reset with a pending response
    axi_write(32'h040, 32'hDEAD, 4'hF, r); check("wr_slverr", r, 2'b10);
    axi_read(32'h040, d, r); check("rd_slverr", {r, d}, {2'b10, 32'h0});
    axi_write(32'h008, 32'hAABB_CCDD, 4'b0101, r);
    axi_read(32'h008, d, r); check("wstrb_merge", d, 32'h00BB_01DD);
    axi_write(32'h008, 32'h1111_1111, 4'b0000, r); check("wstrb0_okay", r, 2'b00);
    axi_read(32'h00B, d, r); check("wstrb0_nochange_a10", d, 32'h00BB_01DD);
    axi_write(32'h010, 32'hFFFF_FFFC, 4'hF, r);
    axi_read(32'h010, d, r); check("ctrl_reserved", d, 32'd0);
    awaddr = 32'h008; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk); awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", bvalid, 1'b1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_bvalid", {bvalid, awready}, 2'b00);
    aresetn = 1'b1;
    ones = 0;
    for (int i = 0; i < 10; i++) begin @(negedge aclk); if (bvalid) ones++; end
    check("no_late_b", ones, 0);
    axi_read(32'h008, d, r); check("post_rst_cmp", d, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
